pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Hazard and stall controller for the 5-stage pipeline. Drives the write enables of the PC and the four pipeline-register banks (all built from enable flip-flops), and inserts bubbles and flushes for load-use hazards, taken branches and multi-cycle data-memory accesses. Counts stall cycles for performance monitoring and latches a sticky error if a memory access never completes.

## Interface
Parameters:
- REG_W, 5, register-specifier width
- ZERO_REG, 31, hardwired-zero register index; never causes a hazard
- TIMEOUT, 64, max consecutive memory-wait cycles before error (>=2)
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- id_rs  in  REG_W  first source register of instruction in ID
- id_rt  in  REG_W  second source register of instruction in ID
- id_uses_rt  in  1  ID instruction reads id_rt
- ex_memread  in  1  instruction in EX is a load
- ex_rd  in  REG_W  destination register of instruction in EX
- branch_taken  in  1  branch resolved taken in ID this cycle
- mem_req  in  1  MEM stage has an active data-memory access
- mem_ready  in  1  data memory completes access this cycle
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register-bank write enables
- ifid_flush  out  1  load NOP into IF/ID
- idex_bubble  out  1  load NOP (all control zero) into ID/EX
- mem_timeout  out  1  sticky error flag
- stall_cnt  out  CNT_W  total stalled cycles, saturating

## Operation
- Combinational terms:
  - freeze = mem_req & ~mem_ready
  - load_use = ex_memread & (ex_rd != ZERO_REG) & ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)))
- FSM states: RUN, WAIT, ERR. Reset state RUN.
  - RUN: freeze -> WAIT (wait_cnt <= 1); else stay.
  - WAIT: ~freeze -> RUN; freeze & wait_cnt == TIMEOUT-1 -> ERR; else wait_cnt++.
  - ERR: terminal until reset; mem_timeout = 1.
- Output priority, highest first:
  - reset=1 or ERR: in ERR all enables 0, flush/bubble 0. In reset all enables 1, flush/bubble 0.
  - freeze (RUN or WAIT): all five enables 0, flush 0, bubble 0.
  - load_use: pc_en=0, ifid_en=0, idex_bubble=1, idex_en/exmem_en/memwb_en=1, ifid_flush=0.
  - branch_taken: all enables 1, ifid_flush=1.
  - otherwise: all enables 1, flush/bubble 0.
- load_use with branch_taken: load_use wins, no flush. The branch re-resolves next cycle.
- stall_cnt increments by 1 on every cycle in which freeze or load_use is honoured, i.e. not in reset or ERR. It saturates at all-ones and never wraps.
- wait_cnt width is clog2(TIMEOUT)+1. It resets to 0 and is internal.

## Timing
- Enables, flush and bubble are combinational from the current inputs and the registered state, with zero-cycle latency. They take effect at the same clock edge as the pipeline registers they control.
- Reset values: state=RUN, wait_cnt=0, stall_cnt=0, mem_timeout=0.
- Load-use costs exactly 1 stall cycle. The next cycle the load is in MEM and the hazard clears.
- Memory handshake: the access completes on the edge where mem_req & mem_ready. That cycle is not a freeze, and the pipeline advances on that edge.
- Timeout: ERR is entered at the edge that ends the TIMEOUT-th consecutive freeze cycle. mem_timeout rises the following cycle.
- Reset asserted mid-WAIT or in ERR: state returns to RUN and counters clear on that edge.

## Test plan
- Load-use: ex_memread=1, ex_rd=3, id_rs=3, no mem_req -> for 1 cycle pc_en=ifid_en=0, idex_bubble=1, other enables 1; stall_cnt 0->1.
- Zero register: same as above but ex_rd=id_rs=31 -> no stall, all enables 1, stall_cnt stays 0. Also id_rt=3 with id_uses_rt=0 -> no stall.
- Memory wait: mem_req=1, mem_ready=0 for 5 cycles, then ready -> all enables 0 for 5 cycles, 1 on the ready cycle; stall_cnt=5; state back to RUN.
- Priority: load_use and branch_taken together -> ifid_flush=0, idex_bubble=1. Freeze together with load_use -> all enables 0, bubble=0.
- Timeout with TIMEOUT=4: mem_ready held 0 -> ERR after 4 freeze cycles, mem_timeout=1 and all enables 0 persistently. Synchronous reset pulse -> mem_timeout=0 and stall_cnt=0.
- Saturation with CNT_W=3: 9 consecutive load-use cycles -> stall_cnt holds at 7.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline: enables, flush/bubble,
// memory-wait tracking with a sticky timeout, and a saturating stall counter.
module pipe_hazard_ctrl #(
  parameter int REG_W    = 5,
  parameter int ZERO_REG = 31,
  parameter int TIMEOUT  = 64,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       dbgState
);

  localparam int WAIT_W = $clog2(TIMEOUT) + 1;

  // Debug encoding is stable: 0 = RUN, 1 = WAIT, 2 = ERR.
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } stateT;

  stateT             state;
  stateT             stateNext;
  logic [WAIT_W-1:0] waitCnt;
  logic [WAIT_W-1:0] waitCntNext;
  logic              freeze;
  logic              loadUse;
  logic              stallEvent;

  // Handshake: an access completes on the edge where mem_req & mem_ready are
  // both high; any cycle with mem_req high and mem_ready low holds the pipe.
  assign freeze  = mem_req & ~mem_ready;
  assign loadUse = ex_memread & (ex_rd != REG_W'(ZERO_REG)) &
                   ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));

  assign stallEvent = (state != ERR) & (freeze | loadUse);
  assign dbgState   = state;

  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    case (state)
      RUN: begin
        if (freeze) begin
          stateNext   = WAIT;
          waitCntNext = WAIT_W'(1);
        end
      end
      WAIT: begin
        if (!freeze) begin
          stateNext   = RUN;
          waitCntNext = '0;
        end else if (waitCnt == WAIT_W'(TIMEOUT - 1)) begin
          stateNext = ERR;
        end else begin
          waitCntNext = waitCnt + WAIT_W'(1);
        end
      end
      ERR:     stateNext = ERR;
      default: stateNext = RUN;
    endcase
  end

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (reset) begin
      // Pipeline registers load their own reset values while reset is high.
    end else if (state == ERR || freeze) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (loadUse) begin
      // A taken branch in the same cycle is dropped; it re-resolves next cycle.
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
    end else if (branch_taken) begin
      ifid_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      waitCnt     <= '0;
      stall_cnt   <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
      if (stallEvent && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (stateNext == ERR) begin
        mem_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (default and TIMEOUT=4/CNT_W=3)
// share stimulus; vector table, directed sequences and random cycles vs a model.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0;
  logic       id_uses_rt = 1'b0, ex_memread = 1'b0, branch_taken = 1'b0;
  logic       mem_req = 1'b0, mem_ready = 1'b0;

  logic [4:0]  enA, enB;
  logic        flushA, flushB, bubbleA, bubbleB, toA, toB;
  logic [15:0] cntA;
  logic [2:0]  cntB;
  logic [1:0]  dbgA, dbgB;

  pipe_hazard_ctrl dutA (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(enA[4]), .ifid_en(enA[3]), .idex_en(enA[2]), .exmem_en(enA[1]), .memwb_en(enA[0]),
    .ifid_flush(flushA), .idex_bubble(bubbleA), .mem_timeout(toA), .stall_cnt(cntA),
    .dbgState(dbgA)
  );

  pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(3)) dutB (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(enB[4]), .ifid_en(enB[3]), .idex_en(enB[2]), .exmem_en(enB[1]), .memwb_en(enB[0]),
    .ifid_flush(flushB), .idex_bubble(bubbleB), .mem_timeout(toB), .stall_cnt(cntB),
    .dbgState(dbgB)
  );

  int nCompared = 0;
  int nMismatched = 0;

  // Reference model: consecutive-freeze run length, error flag, stall total.
  int mTimeout[2] = '{64, 4};
  int mCntMax[2]  = '{65535, 7};
  int mRun[2]     = '{0, 0};
  bit mErr[2]     = '{0, 0};
  int mStall[2]   = '{0, 0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit hazard();
    return ex_memread && ex_rd != 5'd31 &&
           (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
  endfunction

  // Returns {pc, ifid, idex, exmem, memwb, flush, bubble}.
  function automatic logic [6:0] modelOut(input bit err);
    bit fz;
    fz = mem_req && !mem_ready;
    if (reset)             return 7'b11111_0_0;
    else if (err || fz)    return 7'b00000_0_0;
    else if (hazard())     return 7'b00111_0_1;
    else if (branch_taken) return 7'b11111_1_0;
    else                   return 7'b11111_0_0;
  endfunction

  task automatic modelCheck();
    logic [6:0] eA, eB;
    eA = modelOut(mErr[0]);
    eB = modelOut(mErr[1]);
    chk("model_outs_A", {27'd0, enA, flushA, bubbleA}, {25'd0, eA});
    chk("model_outs_B", {27'd0, enB, flushB, bubbleB}, {25'd0, eB});
    chk("model_cnt_A", {16'd0, cntA}, mStall[0]);
    chk("model_cnt_B", {29'd0, cntB}, mStall[1]);
    chk("model_to_A", {31'd0, toA}, {31'd0, mErr[0]});
    chk("model_to_B", {31'd0, toB}, {31'd0, mErr[1]});
  endtask

  task automatic modelUpdate();
    bit fz;
    fz = mem_req && !mem_ready;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        mRun[k] = 0; mErr[k] = 0; mStall[k] = 0;
      end else if (!mErr[k]) begin
        if ((fz || hazard()) && mStall[k] < mCntMax[k]) mStall[k]++;
        if (fz) begin
          mRun[k]++;
          if (mRun[k] >= mTimeout[k]) mErr[k] = 1;
        end else begin
          mRun[k] = 0;
        end
      end
    end
  endtask

  task automatic drive(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic mr, input logic [4:0] rd,
                       input logic br, input logic rq, input logic rdy);
    @(negedge clk);
    reset = r; id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_memread = mr;
    ex_rd = rd; branch_taken = br; mem_req = rq; mem_ready = rdy;
    #1;
    modelCheck();
  endtask

  task automatic adv();
    @(posedge clk);
    modelUpdate();
  endtask

  task automatic idle();
    drive(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
  endtask

  task automatic doReset();
    drive(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    adv();
  endtask

  function automatic logic [4:0] pickReg();
    int v;
    v = $urandom_range(0, 4);
    return (v == 4) ? 5'd31 : 5'(v);
  endfunction

  typedef struct {
    string      nm;
    logic [4:0] rs, rt, rd;
    logic       urt, mr, br, rq, rdy;
    logic [4:0] expEn;
    logic       expFlush, expBubble;
  } vecT;

  vecT vecs[$];

  initial begin
    vecs.push_back('{"idle",        5'd1, 5'd2, 5'd3, 1, 0, 0, 0, 0, 5'b11111, 0, 0});
    vecs.push_back('{"lu_rs",       5'd4, 5'd2, 5'd4, 0, 1, 0, 0, 0, 5'b00111, 0, 1});
    vecs.push_back('{"lu_rt",       5'd1, 5'd6, 5'd6, 1, 1, 0, 0, 0, 5'b00111, 0, 1});
    vecs.push_back('{"rt_unused",   5'd1, 5'd6, 5'd6, 0, 1, 0, 0, 0, 5'b11111, 0, 0});
    vecs.push_back('{"zero_rs",     5'd31, 5'd2, 5'd31, 1, 1, 0, 0, 0, 5'b11111, 0, 0});
    vecs.push_back('{"zero_rt",     5'd1, 5'd31, 5'd31, 1, 1, 0, 0, 0, 5'b11111, 0, 0});
    vecs.push_back('{"no_load",     5'd4, 5'd4, 5'd4, 1, 0, 0, 0, 0, 5'b11111, 0, 0});
    vecs.push_back('{"rd_differs",  5'd4, 5'd5, 5'd6, 1, 1, 0, 0, 0, 5'b11111, 0, 0});
    vecs.push_back('{"branch",      5'd1, 5'd2, 5'd3, 1, 0, 1, 0, 0, 5'b11111, 1, 0});
    vecs.push_back('{"lu_branch",   5'd3, 5'd2, 5'd3, 1, 1, 1, 0, 0, 5'b00111, 0, 1});
    vecs.push_back('{"mem_done",    5'd1, 5'd2, 5'd3, 1, 0, 0, 1, 1, 5'b11111, 0, 0});
    vecs.push_back('{"freeze",      5'd1, 5'd2, 5'd3, 1, 0, 0, 1, 0, 5'b00000, 0, 0});
    vecs.push_back('{"freeze_br",   5'd1, 5'd2, 5'd3, 1, 0, 1, 1, 0, 5'b00000, 0, 0});
    vecs.push_back('{"freeze_lu",   5'd3, 5'd2, 5'd3, 1, 1, 1, 1, 0, 5'b00000, 0, 0});
    vecs.push_back('{"ready_no_req",5'd1, 5'd2, 5'd3, 1, 0, 0, 0, 1, 5'b11111, 0, 0});
  end

  initial begin
    repeat (2) @(posedge clk);

    // Reset state.
    drive(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    chk("reset_en", {27'd0, enA}, 32'h1f);
    chk("reset_flush_bubble", {30'd0, flushA, bubbleA}, 32'd0);
    adv();
    idle();
    chk("reset_cnt", {16'd0, cntA}, 32'd0);
    chk("reset_to", {31'd0, toA}, 32'd0);
    chk("reset_state", {30'd0, dbgA}, 32'd0);
    adv();

    // Vector table.
    foreach (vecs[i]) begin
      drive(0, vecs[i].rs, vecs[i].rt, vecs[i].urt, vecs[i].mr, vecs[i].rd,
            vecs[i].br, vecs[i].rq, vecs[i].rdy);
      chk({"vec_en_", vecs[i].nm}, {27'd0, enA}, {27'd0, vecs[i].expEn});
      chk({"vec_fb_", vecs[i].nm}, {30'd0, flushA, bubbleA},
          {30'd0, vecs[i].expFlush, vecs[i].expBubble});
      adv();
    end

    // Load-use costs one cycle and one count.
    doReset();
    drive(0, 5'd3, 5'd0, 0, 1, 5'd3, 0, 0, 0);
    chk("lu_en", {27'd0, enA}, 32'h07);
    chk("lu_bubble", {31'd0, bubbleA}, 32'd1);
    adv();
    idle();
    chk("lu_cnt", {16'd0, cntA}, 32'd1);
    chk("lu_clear_en", {27'd0, enA}, 32'h1f);
    adv();

    // Zero register and unused rt never stall.
    drive(0, 5'd31, 5'd0, 0, 1, 5'd31, 0, 0, 0);
    chk("zero_en", {27'd0, enA}, 32'h1f);
    adv();
    drive(0, 5'd0, 5'd3, 0, 1, 5'd3, 0, 0, 0);
    chk("rt_unused_en", {27'd0, enA}, 32'h1f);
    adv();
    idle();
    chk("zero_cnt", {16'd0, cntA}, 32'd1);
    adv();

    // Five-cycle memory wait then completion.
    doReset();
    for (int c = 0; c < 5; c++) begin
      drive(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0);
      chk("memwait_en", {27'd0, enA}, 32'd0);
      adv();
    end
    drive(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1);
    chk("memdone_en", {27'd0, enA}, 32'h1f);
    adv();
    idle();
    chk("memwait_cnt", {16'd0, cntA}, 32'd5);
    chk("memwait_state", {30'd0, dbgA}, 32'd0);
    chk("memwait_no_to", {31'd0, toA}, 32'd0);
    adv();

    // Priority corners.
    doReset();
    drive(0, 5'd3, 5'd0, 0, 1, 5'd3, 1, 0, 0);
    chk("prio_lu_br_fb", {30'd0, flushA, bubbleA}, 32'd1);
    adv();
    drive(0, 5'd3, 5'd0, 0, 1, 5'd3, 0, 1, 0);
    chk("prio_fz_lu_en", {27'd0, enA}, 32'd0);
    chk("prio_fz_lu_bubble", {31'd0, bubbleA}, 32'd0);
    adv();

    // Timeout on the TIMEOUT=4 instance.
    doReset();
    for (int c = 0; c < 4; c++) begin
      drive(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0);
      chk("to_before", {31'd0, toB}, 32'd0);
      adv();
    end
    drive(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0);
    chk("to_flag", {31'd0, toB}, 32'd1);
    chk("to_en", {27'd0, enB}, 32'd0);
    adv();
    idle();
    chk("to_sticky", {31'd0, toB}, 32'd1);
    chk("to_sticky_en", {27'd0, enB}, 32'd0);
    chk("to_sticky_cnt", {29'd0, cntB}, 32'd4);
    adv();
    doReset();
    idle();
    chk("to_reset_flag", {31'd0, toB}, 32'd0);
    chk("to_reset_cnt", {29'd0, cntB}, 32'd0);
    chk("to_reset_en", {27'd0, enB}, 32'h1f);
    adv();

    // Saturation on the CNT_W=3 instance.
    doReset();
    for (int c = 0; c < 9; c++) begin
      drive(0, 5'd5, 5'd0, 0, 1, 5'd5, 0, 0, 0);
      adv();
    end
    idle();
    chk("sat_cnt_B", {29'd0, cntB}, 32'd7);
    chk("sat_cnt_A", {16'd0, cntA}, 32'd9);
    adv();

    // Random cycles against the model.
    doReset();
    for (int c = 0; c < 600; c++) begin
      drive(($urandom_range(0, 39) == 0), pickReg(), pickReg(),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pickReg(),
            1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 1)));
      adv();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
